truth_table_sweeper: RTL and testbench

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/truth_table_sweeper.sv | 130 +++++++++++++
 tb/tb_truth_table_sweeper.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Steps a 3-input block through all eight input combinations. Each result is a majority
// vote over repeated samples, and the measured table is compared with a latched expected table.
module truth_table_sweeper #(
   parameter int SETTLE  = 4,
   parameter int SAMPLES = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] expected,
   output logic       in1,
   output logic       in2,
   output logic       in3,
   input  logic       dut_out,
   output logic       busy,
   output logic       done,
   output logic [7:0] table_out,
   output logic       pass
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE - 1);
   localparam logic [3:0] SAMPLES_LAST = 4'(SAMPLES - 1);
   localparam logic [4:0] VOTE_HALF    = 5'(SAMPLES / 2);

   logic [1:0] r_state;
   logic [2:0] r_idx;
   logic [7:0] r_settle_cnt;
   logic [3:0] r_samp_cnt;
   logic [3:0] r_ones;
   logic [7:0] r_expected;
   logic [7:0] r_table;
   logic       r_busy;
   logic       r_done;
   logic       r_pass;

   logic       w_active;
   logic [4:0] w_ones_total;
   logic       w_vote;
   logic       w_sample_end;

   assign w_active     = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
   // The final sample cycle's dut_out is folded into the vote directly.
   assign w_ones_total = {1'b0, r_ones} + {4'b0000, dut_out};
   assign w_vote       = (w_ones_total > VOTE_HALF);
   assign w_sample_end = (r_state == S_SAMPLE) && (r_samp_cnt == SAMPLES_LAST);

   assign {in1, in2, in3} = w_active ? r_idx : 3'b000;
   assign busy      = r_busy;
   assign done      = r_done;
   assign table_out = r_table;
   assign pass      = r_pass;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_idx        <= 3'd0;
         r_settle_cnt <= 8'd0;
         r_samp_cnt   <= 4'd0;
         r_ones       <= 4'd0;
         r_expected   <= 8'h00;
         r_table      <= 8'h00;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_expected   <= expected;
                  r_table      <= 8'h00;
                  r_pass       <= 1'b0;
                  r_idx        <= 3'd0;
                  r_settle_cnt <= 8'd0;
                  r_samp_cnt   <= 4'd0;
                  r_ones       <= 4'd0;
                  r_busy       <= 1'b1;
                  r_state      <= S_SETTLE;
               end
            end
            S_SETTLE, S_SAMPLE: begin
               if (abort) begin
                  r_state      <= S_IDLE;
                  r_busy       <= 1'b0;
                  r_pass       <= 1'b0;
                  r_idx        <= 3'd0;
                  r_settle_cnt <= 8'd0;
                  r_samp_cnt   <= 4'd0;
                  r_ones       <= 4'd0;
               end else if (r_state == S_SETTLE) begin
                  if (r_settle_cnt == SETTLE_LAST) begin
                     r_settle_cnt <= 8'd0;
                     r_state      <= S_SAMPLE;
                  end else begin
                     r_settle_cnt <= r_settle_cnt + 8'd1;
                  end
               end else if (w_sample_end) begin
                  r_table[3'd7 - r_idx] <= w_vote;
                  r_samp_cnt            <= 4'd0;
                  r_ones                <= 4'd0;
                  if (r_idx == 3'd7) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_idx   <= r_idx + 3'd1;
                     r_state <= S_SETTLE;
                  end
               end else begin
                  r_samp_cnt <= r_samp_cnt + 4'd1;
                  r_ones     <= w_ones_total[3:0];
               end
            end
            default: begin
               // Done and pass register here so pass sees the final table bit.
               r_done  <= 1'b1;
               r_pass  <= (r_table == r_expected);
               r_idx   <= 3'd0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: table vectors, random sweeps against a vote model,
// and hand-written abort / reset sequences.
module tb_truth_table_sweeper;

   localparam int ST = 4;
   localparam int SM = 3;
   localparam int P  = ST + SM;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic [7:0] expected;
   logic       in1, in2, in3;
   logic       dut_out;
   logic       busy;
   logic       done;
   logic [7:0] table_out;
   logic       pass;

   int n_vec = 0;
   int n_err = 0;

   truth_table_sweeper #(.SETTLE(ST), .SAMPLES(SM)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .expected  (expected),
      .in1       (in1),
      .in2       (in2),
      .in3       (in3),
      .dut_out   (dut_out),
      .busy      (busy),
      .done      (done),
      .table_out (table_out),
      .pass      (pass)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  truth;
      logic [7:0]  exp_in;
      logic [23:0] flips;
      bit          abort_with_start;
      logic [7:0]  exp_tab;
      logic        exp_pass;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Majority vote per combination over the sampled (possibly inverted) block output.
   function automatic logic [7:0] model_table(input logic [7:0] truth, input logic [23:0] flips);
      logic [7:0] t;
      t = 8'h00;
      for (int i = 0; i < 8; i++) begin
         int ones;
         ones = 0;
         for (int k = 0; k < SM; k++)
            if (truth[7-i] ^ flips[i*SM+k]) ones++;
         t[7-i] = (ones > SM / 2);
      end
      return t;
   endfunction

   task automatic run_sweep(input logic [7:0] truth, input logic [7:0] exp_in,
                            input logic [23:0] flips, input logic [7:0] exp_tab,
                            input logic exp_pass, input int start_at, input int abort_at,
                            input int rst_at, input bit abort_with_start, input string tag);
      logic [2:0] p;
      logic [7:0] part;
      int         i_cur;
      int         ph;
      expected = exp_in;
      start    = 1'b1;
      abort    = abort_with_start;
      @(posedge clk);
      #1;
      start    = 1'b0;
      abort    = 1'b0;
      expected = ~exp_in;
      for (int c = 0; c <= 8*P + 2; c++) begin
         if (c > 0) begin
            @(posedge clk);
            #1;
         end
         if (rst_at >= 0 && c == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk({tag, " rst busy"}, busy, 0);
            chk({tag, " rst done"}, done, 0);
            chk({tag, " rst pass"}, pass, 0);
            chk({tag, " rst table"}, table_out, 0);
            chk({tag, " rst pins"}, {in1, in2, in3}, 0);
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            for (int w = 0; w < 70; w++) begin
               @(posedge clk);
               #1;
               chk({tag, " post-rst done"}, done, 0);
               chk({tag, " post-rst busy"}, busy, 0);
            end
            return;
         end
         if (abort_at >= 0 && c == abort_at + 1) begin
            abort = 1'b0;
            part  = exp_tab;
            for (int i = 0; i < 8; i++)
               if ((i + 1) * P > abort_at) part[7-i] = 1'b0;
            chk({tag, " abort busy"}, busy, 0);
            chk({tag, " abort pins"}, {in1, in2, in3}, 0);
            chk({tag, " abort pass"}, pass, 0);
            chk({tag, " abort table"}, table_out, part);
            chk({tag, " abort done"}, done, 0);
            for (int w = 0; w < 8; w++) begin
               @(posedge clk);
               #1;
               chk({tag, " post-abort done"}, done, 0);
               chk({tag, " post-abort busy"}, busy, 0);
            end
            return;
         end
         start = (c == start_at);
         chk({tag, " done"}, done, (c == 8*P + 1) ? 1 : 0);
         chk({tag, " busy"}, busy, (c < 8*P) ? 1 : 0);
         if (c < 8*P) begin
            i_cur = c / P;
            ph    = c % P;
            chk({tag, " pins"}, {in1, in2, in3}, i_cur);
            p = {in1, in2, in3};
            dut_out = truth[3'd7 - p];
            if (ph >= ST) dut_out = dut_out ^ flips[i_cur*SM + (ph - ST)];
         end else begin
            chk({tag, " pins idle"}, {in1, in2, in3}, 0);
            dut_out = 1'b0;
         end
         if (c == 8*P + 1) begin
            chk({tag, " table"}, table_out, exp_tab);
            chk({tag, " pass"}, pass, exp_pass);
         end
         if (abort_at >= 0 && c == abort_at) abort = 1'b1;
      end
   endtask

   initial begin
      logic [7:0]  r_truth;
      logic [7:0]  r_exp;
      logic [23:0] r_flips;
      logic [7:0]  m;

      vecs[0] = '{8'hB2, 8'hB2, 24'h000000, 1'b0, 8'hB2, 1'b1};
      vecs[1] = '{8'hB2, 8'hB3, 24'h000000, 1'b0, 8'hB2, 1'b0};
      vecs[2] = '{8'hB2, 8'hB2, 24'h462311, 1'b0, 8'hB2, 1'b1};
      vecs[3] = '{8'hB2, 8'hB2, 24'h000003, 1'b0, 8'h32, 1'b0};
      vecs[4] = '{8'hFF, 8'hFF, 24'hE00000, 1'b0, 8'hFE, 1'b0};
      vecs[5] = '{8'h00, 8'h00, 24'h000000, 1'b1, 8'h00, 1'b1};

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; expected = 8'h00; dut_out = 1'b0;
      #12;
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset table", table_out, 0);
      chk("reset pass", pass, 0);
      chk("reset pins", {in1, in2, in3}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      abort = 1'b1;
      for (int w = 0; w < 3; w++) begin
         @(posedge clk);
         #1;
         chk("idle abort busy", busy, 0);
         chk("idle abort done", done, 0);
      end
      abort = 1'b0;

      for (int v = 0; v < 6; v++)
         run_sweep(vecs[v].truth, vecs[v].exp_in, vecs[v].flips, vecs[v].exp_tab,
                   vecs[v].exp_pass, -1, -1, -1, vecs[v].abort_with_start, $sformatf("vec%0d", v));

      for (int r = 0; r < 6; r++) begin
         r_truth = 8'($urandom);
         r_flips = 24'($urandom) & 24'($urandom);
         m       = model_table(r_truth, r_flips);
         r_exp   = ($urandom_range(0, 1) == 1) ? m : 8'($urandom);
         run_sweep(r_truth, r_exp, r_flips, m, (m == r_exp), -1, -1, -1, 1'b0,
                   $sformatf("rand%0d", r));
      end

      run_sweep(8'hB2, 8'hB2, 24'h0, 8'hB2, 1'b0, -1, 3*P + ST, -1, 1'b0, "abort011");
      run_sweep(8'hB2, 8'hB2, 24'h0, 8'hB2, 1'b1, -1, -1, -1, 1'b0, "after-abort");
      run_sweep(8'hFF, 8'hFF, 24'h0, 8'hFF, 1'b0, -1, 8*P - 1, -1, 1'b0, "abort-last");

      run_sweep(8'hB2, 8'hB2, 24'h0, 8'hB2, 1'b1, 10, -1, -1, 1'b0, "start-mid");
      run_sweep(8'hB2, 8'hB2, 24'h0, 8'hB2, 1'b1, -1, -1, 30, 1'b0, "rst-mid");
      run_sweep(8'h5A, 8'h5A, 24'h0, 8'h5A, 1'b1, -1, -1, -1, 1'b0, "after-rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
